// File: rtl/delay_pulse_analyzer.sv
`default_nettype none
// ============================================================================
//  Module      : delay_pulse_analyzer
//  Description : Measures, per channel, the delay from the period marker t0 to
//                the first rising edge of a pulse input and that pulse's high
//                width. Results for each closed period are published as a
//                frame with a valid/ready handshake; frames that cannot be
//                delivered are counted as overruns.
//  Options     : DELAY_PULSE_ANALYZER_PERIOD_EN adds meas_period, the t0-to-t0
//                spacing in clocks, carried with each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_pulse_analyzer #(
  parameter int NCHANNELS = 9,
  parameter int WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       t0,
  input  logic [NCHANNELS-1:0]       pins,
  output logic [NCHANNELS*WIDTH-1:0] meas_delay,
  output logic [NCHANNELS*WIDTH-1:0] meas_width,
  output logic [NCHANNELS-1:0]       rise_seen,
  output logic [NCHANNELS-1:0]       fall_seen,
  output logic                       frame_valid,
  input  logic                       frame_ready,
`ifdef DELAY_PULSE_ANALYZER_PERIOD_EN
  output logic [WIDTH-1:0]           meas_period,
`endif
  output logic [7:0]                 overrun_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Elapsed counter: r_e holds last cycle's value, w_e is this cycle's value
  // (already zero when t0 is high), so captures see the post-load count.
  logic [WIDTH-1:0]           r_e;
  logic [WIDTH-1:0]           w_e;
  logic [NCHANNELS-1:0]       r_prev;
  logic [NCHANNELS-1:0]       w_rise;
  logic [NCHANNELS-1:0]       w_fall;
  logic                       r_started;
  logic                       w_close;
  logic                       w_accept;

  logic [NCHANNELS*WIDTH-1:0] w_snap_delay;
  logic [NCHANNELS*WIDTH-1:0] w_snap_width;
  logic [NCHANNELS-1:0]       w_snap_rise;
  logic [NCHANNELS-1:0]       w_snap_fall;

  logic [NCHANNELS*WIDTH-1:0] r_delay_o;
  logic [NCHANNELS*WIDTH-1:0] r_width_o;
  logic [NCHANNELS-1:0]       r_rise_o;
  logic [NCHANNELS-1:0]       r_fall_o;
  logic                       r_valid;
  logic [7:0]                 r_overrun;

  assign w_e      = t0 ? '0 : ((&r_e) ? r_e : r_e + WIDTH'(1));
  assign w_rise   = pins & ~r_prev;
  assign w_fall   = ~pins & r_prev;
  // Only a t0 after the opening one closes a period and produces a frame.
  assign w_close  = t0 & r_started;
  assign w_accept = r_valid & frame_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NCHANNELS; gi++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nx;
      logic [WIDTH-1:0] r_dly;
      logic [WIDTH-1:0] r_wid;
      logic [WIDTH-1:0] w_dly_nx;
      logic [WIDTH-1:0] w_wid_nx;

      // Channel state and captured delay/width registers.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= S_IDLE;
          r_dly   <= '0;
          r_wid   <= '0;
        end else begin
          r_state <= w_state_nx;
          r_dly   <= w_dly_nx;
          r_wid   <= w_wid_nx;
        end
      end

      // Next state: any t0 restarts from IDLE and still honours its own edge.
      always_comb begin
        w_state_nx = r_state;
        w_dly_nx   = r_dly;
        w_wid_nx   = r_wid;
        if (t0) begin
          if (w_rise[gi]) begin
            w_state_nx = S_HIGH;
            w_dly_nx   = w_e;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_rise[gi]) begin
                w_state_nx = S_HIGH;
                w_dly_nx   = w_e;
              end
            end
            S_HIGH: begin
              if (w_fall[gi]) begin
                w_state_nx = S_DONE;
                w_wid_nx   = w_e - r_dly;
              end
            end
            S_DONE:  w_state_nx = S_DONE;
            default: w_state_nx = S_IDLE;
          endcase
        end
      end

      // Stale captures are masked so idle/open channels report zero.
      assign w_snap_rise[gi] = (r_state != S_IDLE);
      assign w_snap_fall[gi] = (r_state == S_DONE);
      assign w_snap_delay[gi*WIDTH +: WIDTH] = (r_state != S_IDLE) ? r_dly : '0;
      assign w_snap_width[gi*WIDTH +: WIDTH] = (r_state == S_DONE) ? r_wid : '0;
    end
  endgenerate

`ifdef DELAY_PULSE_ANALYZER_PERIOD_EN
  logic [WIDTH-1:0] r_period_o;
`endif

  // Counter, edge history, frame snapshot, handshake and overrun tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e        <= '0;
      r_prev     <= '0;
      r_started  <= 1'b0;
      r_delay_o  <= '0;
      r_width_o  <= '0;
      r_rise_o   <= '0;
      r_fall_o   <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= '0;
`ifdef DELAY_PULSE_ANALYZER_PERIOD_EN
      r_period_o <= '0;
`endif
    end else begin
      r_e    <= w_e;
      r_prev <= pins;
      if (t0) begin
        r_started <= 1'b1;
      end
      if (w_close && (!r_valid || frame_ready)) begin
        // Output slot is free or being freed this cycle: take the new frame.
        r_delay_o  <= w_snap_delay;
        r_width_o  <= w_snap_width;
        r_rise_o   <= w_snap_rise;
        r_fall_o   <= w_snap_fall;
        r_valid    <= 1'b1;
`ifdef DELAY_PULSE_ANALYZER_PERIOD_EN
        r_period_o <= r_e + WIDTH'(1);
`endif
      end else begin
        if (w_close && (r_overrun != 8'hFF)) begin
          r_overrun <= r_overrun + 8'd1;
        end
        if (w_accept) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign meas_delay    = r_delay_o;
  assign meas_width    = r_width_o;
  assign rise_seen     = r_rise_o;
  assign fall_seen     = r_fall_o;
  assign frame_valid   = r_valid;
  assign overrun_count = r_overrun;
`ifdef DELAY_PULSE_ANALYZER_PERIOD_EN
  assign meas_period   = r_period_o;
`endif

endmodule
`default_nettype wire

// File: tb/tb_delay_pulse_analyzer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_pulse_analyzer
//  Description : Directed self-checking bench for delay_pulse_analyzer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_pulse_analyzer;

  localparam int NCH = 9;
  localparam int W   = 32;

  logic             clk;
  logic             reset;
  logic             t0;
  logic [NCH-1:0]   pins;
  logic [NCH*W-1:0] meas_delay;
  logic [NCH*W-1:0] meas_width;
  logic [NCH-1:0]   rise_seen;
  logic [NCH-1:0]   fall_seen;
  logic             frame_valid;
  logic             frame_ready;
  logic [7:0]       overrun_count;
`ifdef DELAY_PULSE_ANALYZER_PERIOD_EN
  logic [W-1:0]     meas_period;
`endif

  int n_pass   = 0;
  int n_checks = 0;

  int ev_e[$];
  int ev_ch[$];
  bit ev_v[$];

  delay_pulse_analyzer #(.NCHANNELS(NCH), .WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .t0            (t0),
    .pins          (pins),
    .meas_delay    (meas_delay),
    .meas_width    (meas_width),
    .rise_seen     (rise_seen),
    .fall_seen     (fall_seen),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
`ifdef DELAY_PULSE_ANALYZER_PERIOD_EN
    .meas_period   (meas_period),
`endif
    .overrun_count (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] dly(input int ch);
    return meas_delay[ch*W +: W];
  endfunction

  function automatic logic [W-1:0] wid(input int ch);
    return meas_width[ch*W +: W];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_ev();
    ev_e.delete();
    ev_ch.delete();
    ev_v.delete();
  endtask

  task automatic add_ev(input int e, input int ch, input bit v);
    ev_e.push_back(e);
    ev_ch.push_back(ch);
    ev_v.push_back(v);
  endtask

  // Drives cycles e0..e1 of a 100-cycle period; t0 is high in the e==0 cycle.
  task automatic run_cycles(input int e0, input int e1);
    for (int e = e0; e <= e1; e++) begin
      t0 = (e == 0);
      for (int k = 0; k < ev_e.size(); k++)
        if (ev_e[k] == e) pins[ev_ch[k]] = ev_v[k];
      @(posedge clk);
      #1;
    end
    t0 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; t0 = 1'b0; pins = '0; frame_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid",   frame_valid,   0);
    check("rst_overrun", overrun_count, 0);
    check("rst_rise",    rise_seen,     0);
    check("rst_delay0",  dly(0),        0);
    reset = 1'b0;
    frame_ready = 1'b1;

    // Opening period: ch0 10..20, ch3 5..6 then ignored repeat, ch1 rises at 90.
    clear_ev();
    add_ev(10, 0, 1); add_ev(20, 0, 0);
    add_ev(5, 3, 1);  add_ev(6, 3, 0); add_ev(40, 3, 1); add_ev(45, 3, 0);
    add_ev(90, 1, 1);
    run_cycles(0, 99);
    check("open_no_frame", frame_valid, 0);

    // Second period: ch2 rises in the close cycle, ch1 stays high throughout.
    clear_ev();
    add_ev(0, 2, 1); add_ev(7, 2, 0);
    run_cycles(0, 0);
    check("f1_valid",  frame_valid, 1);
    check("f1_rise",   rise_seen,   9'b000001011);
    check("f1_fall",   fall_seen,   9'b000001001);
    check("f1_dly0",   dly(0), 10);
    check("f1_wid0",   wid(0), 10);
    check("f1_dly3",   dly(3), 5);
    check("f1_wid3",   wid(3), 1);
    check("f1_dly1",   dly(1), 90);
    check("f1_wid1",   wid(1), 0);
    check("f1_dly2",   dly(2), 0);
    check("f1_ovr",    overrun_count, 0);
`ifdef DELAY_PULSE_ANALYZER_PERIOD_EN
    check("f1_period", meas_period, 100);
`endif
    run_cycles(1, 1);
    check("f1_accepted", frame_valid, 0);
    run_cycles(2, 99);

    // Third period: ch4 3..8, ch1 finally falls (ignored, no rise).
    clear_ev();
    add_ev(3, 4, 1); add_ev(8, 4, 0); add_ev(50, 1, 0);
    run_cycles(0, 0);
    check("f2_rise", rise_seen, 9'b000000100);
    check("f2_fall", fall_seen, 9'b000000100);
    check("f2_dly2", dly(2), 0);
    check("f2_wid2", wid(2), 7);
    frame_ready = 1'b0;
    run_cycles(1, 99);

    // Fourth period: consumer stalled, closes overrun.
    clear_ev();
    add_ev(20, 7, 1); add_ev(21, 7, 0);
    run_cycles(0, 0);
    check("ovr1_count", overrun_count, 1);
    check("ovr1_held",  rise_seen,     9'b000000100);
    check("ovr1_wid2",  wid(2),        7);
    run_cycles(1, 99);

    // Fifth period: ch5 12..30; ready rises mid-period.
    clear_ev();
    add_ev(12, 5, 1); add_ev(30, 5, 0);
    run_cycles(0, 0);
    check("ovr2_count", overrun_count, 2);
    check("ovr2_valid", frame_valid,   1);
    check("ovr2_wid2",  wid(2),        7);
    run_cycles(1, 49);
    frame_ready = 1'b1;
    run_cycles(50, 99);
    check("ovr2_accepted", frame_valid, 0);

    // Sixth period: ch6 1..2; close lands on a fresh frame, count unchanged.
    clear_ev();
    add_ev(1, 6, 1); add_ev(2, 6, 0);
    run_cycles(0, 0);
    check("f5_valid", frame_valid,   1);
    check("f5_rise",  rise_seen,     9'b000100000);
    check("f5_dly5",  dly(5),        12);
    check("f5_wid5",  wid(5),        18);
    check("f5_ovr",   overrun_count, 2);
`ifdef DELAY_PULSE_ANALYZER_PERIOD_EN
    check("f5_period", meas_period, 100);
`endif
    frame_ready = 1'b0;
    run_cycles(1, 99);
    frame_ready = 1'b1;

    // Close coincident with acceptance: new frame loads, valid stays high.
    clear_ev();
    run_cycles(0, 0);
    check("f6_valid", frame_valid,   1);
    check("f6_rise",  rise_seen,     9'b001000000);
    check("f6_dly6",  dly(6),        1);
    check("f6_wid6",  wid(6),        1);
    check("f6_ovr",   overrun_count, 2);
    run_cycles(1, 1);
    check("f6_accepted", frame_valid, 0);

    // Overrun counter saturation with short periods and a stalled consumer.
    frame_ready = 1'b0;
    for (int n = 0; n < 260; n++) run_cycles(0, 2);
    check("sat_count", overrun_count, 255);
    check("sat_valid", frame_valid,   1);

    // Mid-period reset drops the pending frame and the opening-t0 state.
    run_cycles(0, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mrst_valid",   frame_valid,   0);
    check("mrst_overrun", overrun_count, 0);
    check("mrst_rise",    rise_seen,     0);
    check("mrst_wid2",    wid(2),        0);
    frame_ready = 1'b1;
    clear_ev();
    add_ev(10, 0, 1); add_ev(20, 0, 0);
    run_cycles(0, 0);
    check("mrst_open_no_frame", frame_valid, 0);
    run_cycles(1, 99);
    clear_ev();
    run_cycles(0, 0);
    check("post_valid", frame_valid, 1);
    check("post_rise",  rise_seen,   9'b000000001);
    check("post_fall",  fall_seen,   9'b000000001);
    check("post_dly0",  dly(0),      10);
    check("post_wid0",  wid(0),      10);
    run_cycles(1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_pulse_analyzer.md
DELAY_PULSE_ANALYZER -- requirements
Module: delay_pulse_analyzer

Interface
REQ-001 Parameter NCHANNELS, default 9: number of pulse input channels analysed.
REQ-002 Parameter WIDTH, default 32: bit width of the elapsed counter and of every delay/width result.
REQ-003 clk  input  1  single clock; all logic in this domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 t0  input  1  period marker; one-clock pulse, synchronous to clk.
REQ-006 pins  input  NCHANNELS  pulse inputs, synchronous to clk; bit i is channel i.
REQ-007 meas_delay  output  NCHANNELS*WIDTH  per-channel rise delay; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 meas_width  output  NCHANNELS*WIDTH  per-channel high width, same packing.
REQ-009 rise_seen  output  NCHANNELS  per-channel flag: a rising edge was captured in the frame.
REQ-010 fall_seen  output  NCHANNELS  per-channel flag: a falling edge was captured after the rise.
REQ-011 frame_valid  output  1  result frame available.
REQ-012 frame_ready  input  1  consumer accepts the frame when frame_valid and frame_ready are both high.
REQ-013 overrun_count  output  8  count of frames lost to overrun; saturates at 255.

Function
REQ-014 Elapsed counter E: loads 0 in every cycle t0 is high; otherwise increments by 1; saturates at all-ones.
REQ-015 Edge detection: compare pins with a one-cycle-delayed copy; rise = pins & ~prev; fall = ~pins & prev.
REQ-016 Per-channel FSM states: IDLE, HIGH, DONE.
REQ-017 IDLE with rise: capture delay = E (value after any t0 load that cycle); go to HIGH.
REQ-018 HIGH with fall: capture width = E - captured delay, WIDTH bits, unsigned; go to DONE.
REQ-019 DONE: ignore all further edges until the period closes (first pulse per period only).
REQ-020 Period close: each t0 after the first t0 following reset closes the previous period.
REQ-021 The first t0 after reset opens a period only and emits no frame.
REQ-022 At close, snapshot every channel's delay/width/rise/fall into output registers; frame_valid goes high the next cycle.
REQ-023 Channel still in HIGH at close: rise_seen=1, fall_seen=0, width=0.
REQ-024 Channel in IDLE at close: rise_seen=0, fall_seen=0, delay=0, width=0.
REQ-025 In the close cycle all FSMs return to IDLE, then evaluate that cycle's edges with E=0.
REQ-026 An edge coincident with t0 belongs to the new period; a pin already high at close does not create a rise.
REQ-027 frame_valid stays high, with outputs stable, until accepted; it clears the cycle after acceptance unless a new snapshot loads.
REQ-028 Close while frame_valid=1 and frame_ready=0: discard the new snapshot, keep the held outputs, and increment overrun_count.
REQ-029 Close in the same cycle as acceptance: load the new snapshot, keep frame_valid high, no overrun.
REQ-030 No combinational path from any input to any output.

Reset
REQ-031 While reset is high, at the clock edge: E=0; all FSMs IDLE; prev=0; all outputs 0; the "first t0 seen" flag is cleared.
REQ-032 Reset mid-period or mid-handshake drops any pending frame; the next t0 only opens a period.

Configuration
REQ-033 Macro DELAY_PULSE_ANALYZER_PERIOD_EN defined: add output meas_period [WIDTH-1:0], snapshotted at close as E+1 from the closing cycle (t0-to-t0 spacing in clocks), held and handshaked with the frame, reset 0.
REQ-034 Macro not defined: no meas_period port and no related logic; all other behaviour is identical.

Verification
REQ-035 t0 every 100 cycles; ch0 high from E=10 to E=20; frame_ready=1 -> ch0 delay=10, width=10, rise_seen[0]=fall_seen[0]=1; other channels all 0.
REQ-036 ch3 rises at E=5, falls at E=6, rises again at E=40 -> delay=5, width=1; the second pulse is ignored.
REQ-037 ch1 rises at E=90 and is still high at the next t0 -> rise_seen[1]=1, fall_seen[1]=0, width=0; the next frame has rise_seen[1]=0 if ch1 stays high.
REQ-038 frame_ready=0 across 3 closes -> the first frame is held unchanged and overrun_count=2; raising ready plus one more close -> new frame, count stays 2.
REQ-039 Reset pulse mid-period with frame_valid=1 -> all outputs 0 next cycle; the first subsequent t0 produces no frame.
REQ-040 With DELAY_PULSE_ANALYZER_PERIOD_EN and t0 spacing 100 -> meas_period=100 in every frame after the first.
